// File: rtl/ir_pkg.sv
// Shared constants and state type for the IR weight streamer.
package ir_pkg;

   localparam int unsigned IR_N_POINTS = 64;
   localparam int unsigned IR_WORD_W   = 16;
   localparam int unsigned IR_ADDR_W   = 6;
   localparam int unsigned IR_CNT_W    = IR_ADDR_W + 1;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDone
   } ir_stream_state_t;

endpackage

// File: rtl/ir_weight_streamer_if.sv
// Output stream handshake carrying one complex weight per beat.
interface ir_weight_streamer_if
   import ir_pkg::*;
#(
   parameter int unsigned WORD_W = IR_WORD_W
) ();

   logic                 o_valid;
   logic                 i_ready;
   logic [WORD_W-1:0]    o_re;
   logic [WORD_W-1:0]    o_im;
   logic [IR_ADDR_W-1:0] o_index;
   logic                 o_last;

   modport master (
      output o_valid,
      output o_re,
      output o_im,
      output o_index,
      output o_last,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_re,
      input  o_im,
      input  o_index,
      input  o_last,
      output i_ready
   );

endinterface

// File: rtl/ir_conj_sat.sv
// Saturating two's-complement negate: the most negative value maps to the most positive.
module ir_conj_sat #(
   parameter int unsigned Width = 16
) (
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] d_o
);

   localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

   always_comb begin
      if (d_i == MinVal) begin
         d_o = ~MinVal;
      end else begin
         d_o = -d_i;
      end
   end

endmodule

// File: rtl/ir_weight_streamer.sv
// Streams N_POINTS complex weights from an external combinational table, optionally conjugated.
module ir_weight_streamer
   import ir_pkg::*;
#(
   parameter int unsigned N_POINTS = IR_N_POINTS,
   parameter int unsigned WORD_W   = IR_WORD_W
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic                 i_conj,
   output logic [IR_ADDR_W-1:0] o_rom_addr,
   input  logic [WORD_W-1:0]    i_rom_re,
   input  logic [WORD_W-1:0]    i_rom_im,
   ir_weight_streamer_if.master strm,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [IR_CNT_W-1:0] LastIdx = IR_CNT_W'(N_POINTS - 1);
   localparam logic [IR_CNT_W-1:0] CntOne  = IR_CNT_W'(1);

   ir_stream_state_t     state_q, state_d;
   logic [IR_CNT_W-1:0]  cnt_q, cnt_d;
   logic                 conj_q, conj_d;
   logic                 valid_q, valid_d;
   logic [WORD_W-1:0]    re_q, re_d;
   logic [WORD_W-1:0]    im_q, im_d;
   logic [IR_ADDR_W-1:0] index_q, index_d;
   logic                 last_q, last_d;

   logic [IR_CNT_W-1:0]  issue_idx;
   logic [WORD_W-1:0]    im_neg;
   logic                 conj_sel;
   logic                 load;

   ir_conj_sat #(
      .Width (WORD_W)
   ) u_conj_sat (
      .d_i (i_rom_im),
      .d_o (im_neg)
   );

   // The first beat is loaded in IDLE, before i_conj has been latched.
   assign conj_sel   = (state_q == StIdle) ? i_conj : conj_q;
   assign issue_idx  = (state_q == StStream) ? cnt_q : '0;
   assign o_rom_addr = issue_idx[IR_ADDR_W-1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      conj_d  = conj_q;
      valid_d = valid_q;
      re_d    = re_q;
      im_d    = im_q;
      index_d = index_q;
      last_d  = last_q;
      load    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (i_start && !i_abort) begin
               load    = 1'b1;
               conj_d  = i_conj;
               state_d = StStream;
            end
         end
         StStream: begin
            if (i_abort) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end else if (valid_q && strm.i_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  state_d = StDone;
               end else begin
                  load = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase

      if (load) begin
         valid_d = 1'b1;
         re_d    = i_rom_re;
         im_d    = conj_sel ? im_neg : i_rom_im;
         index_d = issue_idx[IR_ADDR_W-1:0];
         last_d  = (issue_idx == LastIdx);
         cnt_d   = issue_idx + CntOne;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         conj_q  <= 1'b0;
         valid_q <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         conj_q  <= conj_d;
         valid_q <= valid_d;
         re_q    <= re_d;
         im_q    <= im_d;
         index_q <= index_d;
         last_q  <= last_d;
      end
   end

   assign strm.o_valid = valid_q;
   assign strm.o_re    = re_q;
   assign strm.o_im    = im_q;
   assign strm.o_index = index_q;
   assign strm.o_last  = last_q;
   assign o_busy       = (state_q != StIdle);
   assign o_done       = (state_q == StDone);

endmodule

// File: tb/tb_ir_weight_streamer.sv
// Scoreboard bench for ir_weight_streamer driven from a stub weight table.
module tb_ir_weight_streamer;
   import ir_pkg::*;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic [5:0]  idx;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset, start, abort, conj, force_min;
   logic [5:0]  rom_addr;
   logic [15:0] rom_re, rom_im;
   logic        busy, done;
   int          n_checks = 0;
   int          n_fail   = 0;
   beat_t       q[$];

   always #5 clk = ~clk;

   ir_weight_streamer_if strm ();

   ir_weight_streamer dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_abort    (abort),
      .i_conj     (conj),
      .o_rom_addr (rom_addr),
      .i_rom_re   (rom_re),
      .i_rom_im   (rom_im),
      .strm       (strm),
      .o_busy     (busy),
      .o_done     (done)
   );

   function automatic logic [15:0] tbl_re(input int a);
      case (a)
         0:       return 16'h2A52;
         1:       return 16'h41BB;
         5:       return 16'h0DAA;
         63:      return 16'h41BB;
         default: return 16'(a * 291 + 4369);
      endcase
   endfunction

   function automatic logic [15:0] tbl_im(input int a);
      case (a)
         0:       return 16'h0000;
         1:       return 16'hC876;
         5:       return 16'h9508;
         63:      return 16'h378A;
         default: return 16'((a * 855) ^ 160);
      endcase
   endfunction

   function automatic logic [15:0] stub_im(input int a);
      return force_min ? 16'h8000 : tbl_im(a);
   endfunction

   function automatic logic [15:0] neg_sat(input logic [15:0] v);
      return (v == 16'h8000) ? 16'h7FFF : 16'(0 - int'(v));
   endfunction

   assign rom_re = tbl_re(int'(rom_addr));
   assign rom_im = stub_im(int'(rom_addr));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(strm.o_valid), 32'd0);
      check_eq({tag, "_last"},  32'(strm.o_last),  32'd0);
      check_eq({tag, "_busy"},  32'(busy),         32'd0);
      check_eq({tag, "_done"},  32'(done),         32'd0);
      check_eq({tag, "_re"},    32'(strm.o_re),    32'd0);
      check_eq({tag, "_im"},    32'(strm.o_im),    32'd0);
      check_eq({tag, "_index"}, 32'(strm.o_index), 32'd0);
      check_eq({tag, "_addr"},  32'(rom_addr),     32'd0);
   endtask

   task automatic run(input bit cj, input int stall_idx, input int abort_idx,
                      input int restart_idx, input int reset_idx);
      beat_t b;
      int    beats;
      int    cyc;
      bit    stop;
      q.delete();
      for (int i = 0; i < 64; i++) begin
         b.re   = tbl_re(i);
         b.im   = cj ? neg_sat(stub_im(i)) : stub_im(i);
         b.idx  = 6'(i);
         b.last = (i == 63);
         q.push_back(b);
      end
      start = 1'b1;
      conj  = cj;
      strm.i_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      conj  = ~cj;
      beats = 0;
      cyc   = 0;
      stop  = 1'b0;
      while (!stop && beats < 64 && cyc < 400) begin
         cyc++;
         check_eq("valid", 32'(strm.o_valid), 32'd1);
         if (!strm.o_valid || q.size() == 0) begin
            stop = 1'b1;
         end else begin
            b = q.pop_front();
            check_eq("re",    32'(strm.o_re),    32'(b.re));
            check_eq("im",    32'(strm.o_im),    32'(b.im));
            check_eq("index", 32'(strm.o_index), 32'(b.idx));
            check_eq("last",  32'(strm.o_last),  32'(b.last));
            if (cj && !force_min && b.idx == 6'd1) check_eq("conj_im1", 32'(strm.o_im), 32'h378A);
            if (force_min && b.idx == 6'd0) check_eq("sat_im", 32'(strm.o_im), 32'h7FFF);
            if (int'(b.idx) == stall_idx) begin
               strm.i_ready = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  check_eq("stall_valid", 32'(strm.o_valid), 32'd1);
                  check_eq("stall_re",    32'(strm.o_re),    32'(b.re));
                  check_eq("stall_im",    32'(strm.o_im),    32'(b.im));
                  check_eq("stall_index", 32'(strm.o_index), 32'(b.idx));
               end
               strm.i_ready = 1'b1;
            end
            if (int'(b.idx) == abort_idx) begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               check_eq("abort_valid", 32'(strm.o_valid), 32'd0);
               check_eq("abort_busy",  32'(busy),         32'd0);
               repeat (3) begin
                  check_eq("abort_done", 32'(done), 32'd0);
                  @(negedge clk);
               end
               stop = 1'b1;
            end else if (int'(b.idx) == reset_idx) begin
               reset = 1'b1;
               start = 1'b1;
               @(negedge clk);
               reset = 1'b0;
               start = 1'b0;
               check_reset_outputs("midrst");
               @(negedge clk);
               check_eq("midrst_idle_valid", 32'(strm.o_valid), 32'd0);
               check_eq("midrst_idle_busy",  32'(busy),         32'd0);
               stop = 1'b1;
            end else begin
               if (int'(b.idx) == restart_idx) start = 1'b1;
               beats++;
               @(negedge clk);
               start = 1'b0;
            end
         end
      end
      if (abort_idx < 0 && reset_idx < 0) begin
         check_eq("beats",      32'(beats),        32'd64);
         check_eq("done_pulse", 32'(done),         32'd1);
         check_eq("done_valid", 32'(strm.o_valid), 32'd0);
         check_eq("done_busy",  32'(busy),         32'd1);
         @(negedge clk);
         check_eq("post_done", 32'(done), 32'd0);
         check_eq("post_busy", 32'(busy), 32'd0);
      end
      q.delete();
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      conj         = 1'b0;
      force_min    = 1'b0;
      strm.i_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      run(1'b0, -1, -1, -1, -1);
      run(1'b1, -1, -1, -1, -1);
      force_min = 1'b1;
      run(1'b1, -1, -1, -1, -1);
      force_min = 1'b0;
      run(1'b0, 5, -1, -1, -1);
      run(1'b0, -1, 10, -1, -1);
      run(1'b0, -1, -1, -1, -1);
      run(1'b0, -1, -1, 20, -1);
      run(1'b0, -1, -1, -1, 30);

      abort = 1'b1;
      start = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      check_eq("idle_abort_valid", 32'(strm.o_valid), 32'd0);
      check_eq("idle_abort_busy",  32'(busy),         32'd0);
      @(negedge clk);
      check_eq("idle_abort_valid2", 32'(strm.o_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
